wb_regfile_unit: RTL and testbench
==================================

Name: wb_regfile_unit

Overview:
- Consumer end of the MEM/WB pipeline register in the pipelined RISC-V core.
- Selects the write-back value from the MEM/WB fields, commits it into the 32x32 architectural register file, and serves the two ID-stage read ports.
- Reads are write-through: a same-cycle write is visible on the read ports.
- Exports the WB-stage forwarding tuple to the EX forwarding unit.

Parameters:
- XLEN, 32, data width of registers and write-back sources.
- SP_INIT, 32'h0000_0FFC, reset value of x2 (sp).
- GP_INIT, 32'h0000_0000, reset value of x3 (gp).

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- WB_ctrl_i  in  3  [2]=RegWrite; [1:0]=WB select: 00 ALU, 01 DM, 10 PC+4, 11 reserved.
- DM_i  in  XLEN  load data from MEM/WB.
- alu_result_i  in  XLEN  ALU result from MEM/WB.
- pc_add4_i  in  XLEN  link value from MEM/WB.
- rd_index_i  in  5  destination register.
- rs1_index_i  in  5  ID read port 1 index.
- rs2_index_i  in  5  ID read port 2 index.
- rs1_data_o  out  XLEN  read port 1 data.
- rs2_data_o  out  XLEN  read port 2 data.
- wb_fwd_en_o  out  1  WB stage will write a nonzero rd this cycle.
- wb_fwd_index_o  out  5  rd being written.
- wb_fwd_data_o  out  XLEN  selected write-back value.
- wr_count_o  out  32  count of committed register writes.

Behaviour:
- Reset is asynchronous on the falling edge of rst_i and holds while rst_i=0.
  - x2 := SP_INIT, x3 := GP_INIT, all other registers := 0.
  - wr_count_o := 0.
- Write-back select is combinational:
  - wb_data = 00 -> alu_result_i; 01 -> DM_i; 10 -> pc_add4_i.
  - 11 (reserved) -> alu_result_i. The write still commits if RegWrite=1.
- Write enable: we = WB_ctrl_i[2] && (rd_index_i != 0).
- Commit: on the rising edge with rst_i=1 and we=1, regs[rd_index_i] <= wb_data and wr_count_o increments by 1.
  - wr_count_o wraps modulo 2^32 with no saturation.
- x0 is hardwired: reads always return 0, writes are silently dropped, and a dropped write does not increment wr_count_o.
- Read ports are combinational, zero latency.
  - If rsN_index == 0, output 0.
  - Else if we && rsN_index == rd_index_i, output wb_data (internal bypass, same cycle).
  - Else output regs[rsN_index].
  - Both ports may hit the bypass simultaneously.
- Forwarding tuple is combinational:
  - wb_fwd_en_o = we, wb_fwd_index_o = rd_index_i, wb_fwd_data_o = wb_data.
  - With rd=0 or RegWrite=0, wb_fwd_en_o=0; index and data still reflect the inputs.
- Bubble: WB_ctrl_i=000 (the MEM/WB reset/flush value) causes no write and no count.
- Reset asserted mid-operation:
  - A write whose edge coincides with rst_i=0 is discarded.
  - Registers show reset values immediately.
  - Read ports reflect reset values combinationally; the bypass is still active if inputs request a write.
- Back-to-back writes to the same rd commit in order; the last one wins.

Decomposition:
- Shared package (riscv_pkg):
  - WB_SEL_ALU=2'b00, WB_SEL_DM=2'b01, WB_SEL_PC4=2'b10.
  - WB_CTRL_REGWRITE_BIT=2.
  - REG_ZERO=5'd0, REG_SP=5'd2, REG_GP=5'd3.
  - These WB_ctrl encoding constants are shared with the control unit and MEM/WB register.
- One sub-module: regfile_2r1w (32xXLEN array, async reset with SP/GP init, x0 gating, write-through bypass).
- wb_regfile_unit adds the select mux, forwarding tuple and write counter.

Test Plan:
- Reset: drop rst_i mid-clock -> immediately rs1 idx 2 reads 32'h0000_0FFC, idx 3 reads 0, idx 5 reads 0, wr_count_o=0.
- Source select: WB_ctrl=3'b100/101/110 to rd=5 with alu=32'h11, DM=32'h22, pc4=32'h33 on successive edges -> x5 reads 32'h11, then 32'h22, then 32'h33; wr_count_o=3.
- x0 and bubble:
  - WB_ctrl=3'b101, rd=0, DM=32'hDEAD -> rs1 idx 0 reads 0, wr_count_o unchanged, wb_fwd_en_o=0.
  - WB_ctrl=3'b000, rd=7 -> x7 unchanged.
- Bypass: x9=32'hA; same cycle WB_ctrl=3'b100, rd=9, alu=32'hB, rs1=rs2=9 -> both read 32'hB before the edge; after the edge x9=32'hB.
- Reset mid-write: rst_i=0 overlapping an edge with write rd=4 data 32'h55 -> x4=0 after release; wr_count_o=0.
- Counter wrap: preload count via 2^32-1 writes (or force) then one write -> wr_count_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Encodings shared by the control unit, the MEM/WB register and the write-back stage.
// Covers the WB_ctrl field layout and the architectural register numbers with special roles.
package riscv_pkg;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_DM  = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;

   localparam int unsigned WB_CTRL_REGWRITE_BIT = 2;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd2;
   localparam logic [4:0] REG_GP   = 5'd3;

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry architectural register file: two combinational read ports, one write port.
// Reads bypass a same-cycle write; x0 reads as zero and ignores writes.
module regfile_2r1w
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN    = 32,
   parameter logic [XLEN-1:0] SP_INIT = 32'h0000_0FFC,
   parameter logic [XLEN-1:0] GP_INIT = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            we_i,
   input  logic [4:0]      wr_index_i,
   input  logic [XLEN-1:0] wr_data_i,
   input  logic [4:0]      rs1_index_i,
   input  logic [4:0]      rs2_index_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o
);

   logic [XLEN-1:0] regs_q [32];
   logic            we;

   assign we = we_i && (wr_index_i != REG_ZERO);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         regs_q[REG_SP] <= SP_INIT;
         regs_q[REG_GP] <= GP_INIT;
      end else if (we) begin
         regs_q[wr_index_i] <= wr_data_i;
      end
   end

   // Bypass stays live during reset so ID sees the value WB is presenting.
   always_comb begin
      rs1_data_o = regs_q[rs1_index_i];
      if (rs1_index_i == REG_ZERO) begin
         rs1_data_o = '0;
      end else if (we && (rs1_index_i == wr_index_i)) begin
         rs1_data_o = wr_data_i;
      end
   end

   always_comb begin
      rs2_data_o = regs_q[rs2_index_i];
      if (rs2_index_i == REG_ZERO) begin
         rs2_data_o = '0;
      end else if (we && (rs2_index_i == wr_index_i)) begin
         rs2_data_o = wr_data_i;
      end
   end

endmodule

// File: rtl/wb_regfile_unit.sv
// Write-back stage: selects the MEM/WB result, commits it to the register file,
// exports the WB forwarding tuple and counts committed writes.
module wb_regfile_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN    = 32,
   parameter logic [XLEN-1:0] SP_INIT = 32'h0000_0FFC,
   parameter logic [XLEN-1:0] GP_INIT = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [2:0]      WB_ctrl_i,
   input  logic [XLEN-1:0] DM_i,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [XLEN-1:0] pc_add4_i,
   input  logic [4:0]      rd_index_i,
   input  logic [4:0]      rs1_index_i,
   input  logic [4:0]      rs2_index_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic            wb_fwd_en_o,
   output logic [4:0]      wb_fwd_index_o,
   output logic [XLEN-1:0] wb_fwd_data_o,
   output logic [31:0]     wr_count_o
);

   logic [XLEN-1:0] wb_data;
   logic            reg_write;
   logic            we;
   logic [31:0]     wr_count_q;

   assign reg_write = WB_ctrl_i[WB_CTRL_REGWRITE_BIT];
   assign we        = reg_write && (rd_index_i != REG_ZERO);

   // The reserved select falls back to the ALU result; the write still commits.
   always_comb begin
      unique case (WB_ctrl_i[1:0])
         WB_SEL_DM:  wb_data = DM_i;
         WB_SEL_PC4: wb_data = pc_add4_i;
         default:    wb_data = alu_result_i;
      endcase
   end

   regfile_2r1w #(
      .XLEN    (XLEN),
      .SP_INIT (SP_INIT),
      .GP_INIT (GP_INIT)
   ) u_regfile (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .we_i        (reg_write),
      .wr_index_i  (rd_index_i),
      .wr_data_i   (wb_data),
      .rs1_index_i (rs1_index_i),
      .rs2_index_i (rs2_index_i),
      .rs1_data_o  (rs1_data_o),
      .rs2_data_o  (rs2_data_o)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_count_q <= '0;
      end else if (we) begin
         wr_count_q <= wr_count_q + 32'd1;
      end
   end

   assign wr_count_o     = wr_count_q;
   assign wb_fwd_en_o    = we;
   assign wb_fwd_index_o = rd_index_i;
   assign wb_fwd_data_o  = wb_data;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit: a driver pushes expected outputs computed from
// an array model; a negedge monitor pops and compares against the DUT.
module tb_wb_regfile_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [2:0]  WB_ctrl_i = '0;
   logic [31:0] DM_i = '0;
   logic [31:0] alu_result_i = '0;
   logic [31:0] pc_add4_i = '0;
   logic [4:0]  rd_index_i = '0;
   logic [4:0]  rs1_index_i = '0;
   logic [4:0]  rs2_index_i = '0;
   logic [31:0] rs1_data_o;
   logic [31:0] rs2_data_o;
   logic        wb_fwd_en_o;
   logic [4:0]  wb_fwd_index_o;
   logic [31:0] wb_fwd_data_o;
   logic [31:0] wr_count_o;

   wb_regfile_unit dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .WB_ctrl_i      (WB_ctrl_i),
      .DM_i           (DM_i),
      .alu_result_i   (alu_result_i),
      .pc_add4_i      (pc_add4_i),
      .rd_index_i     (rd_index_i),
      .rs1_index_i    (rs1_index_i),
      .rs2_index_i    (rs2_index_i),
      .rs1_data_o     (rs1_data_o),
      .rs2_data_o     (rs2_data_o),
      .wb_fwd_en_o    (wb_fwd_en_o),
      .wb_fwd_index_o (wb_fwd_index_o),
      .wb_fwd_data_o  (wb_fwd_data_o),
      .wr_count_o     (wr_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        fen;
      logic [4:0]  fidx;
      logic [31:0] fdata;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_regs[2] = 32'h0000_0FFC;
      m_regs[3] = 32'h0000_0000;
      m_cnt = 32'h0;
   endfunction

   task automatic check(input string name, input string field, input logic [31:0] act,
                        input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
      end
   endtask

   always @(negedge clk_i) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.name, "rs1", rs1_data_o, e.rs1);
         check(e.name, "rs2", rs2_data_o, e.rs2);
         check(e.name, "fwd_en", {31'h0, wb_fwd_en_o}, {31'h0, e.fen});
         check(e.name, "fwd_idx", {27'h0, wb_fwd_index_o}, {27'h0, e.fidx});
         check(e.name, "fwd_data", wb_fwd_data_o, e.fdata);
         check(e.name, "count", wr_count_o, e.cnt);
      end
   end

   // Drive one cycle of inputs just after the rising edge and predict the outputs.
   task automatic step(input string name, input logic rst, input logic [2:0] ctrl,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc4, input logic [4:0] rs1, input logic [4:0] rs2);
      exp_t        e;
      logic [31:0] wbd;
      logic        we;
      @(posedge clk_i);
      #1;
      rst_i = rst; WB_ctrl_i = ctrl; rd_index_i = rd; alu_result_i = alu;
      DM_i = dm; pc_add4_i = pc4; rs1_index_i = rs1; rs2_index_i = rs2;
      if (!rst) model_reset();
      wbd = (ctrl[1:0] == 2'b01) ? dm : (ctrl[1:0] == 2'b10) ? pc4 : alu;
      we  = ctrl[2] && (rd != 5'd0);
      e.name  = name;
      e.rs1   = (rs1 == 0) ? 32'h0 : (we && rs1 == rd) ? wbd : m_regs[rs1];
      e.rs2   = (rs2 == 0) ? 32'h0 : (we && rs2 == rd) ? wbd : m_regs[rs2];
      e.fen   = we;
      e.fidx  = rd;
      e.fdata = wbd;
      e.cnt   = m_cnt;
      exp_q.push_back(e);
      if (rst && we) begin
         m_regs[rd] = wbd;
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk_i);
      step("reset_state", 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd3);
      step("sel_alu", 1'b1, 3'b100, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd2);
      step("sel_dm", 1'b1, 3'b101, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd0);
      step("sel_pc4", 1'b1, 3'b110, 5'd5, 32'h11, 32'h22, 32'h33, 5'd5, 5'd3);
      step("sel_read", 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
      step("x0_drop", 1'b1, 3'b101, 5'd0, 32'h1, 32'hDEAD, 32'h2, 5'd0, 5'd5);
      step("bubble", 1'b1, 3'b000, 5'd7, 32'h99, 32'h98, 32'h97, 5'd7, 5'd0);
      step("bubble_rd", 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0);
      step("bypass_pre", 1'b1, 3'b100, 5'd9, 32'hA, 32'h0, 32'h0, 5'd9, 5'd1);
      step("bypass", 1'b1, 3'b100, 5'd9, 32'hB, 32'h0, 32'h0, 5'd9, 5'd9);
      step("bypass_post", 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9);
      step("reserved", 1'b1, 3'b111, 5'd10, 32'h77, 32'h88, 32'h66, 5'd1, 5'd2);
      step("reserved_rd", 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd10, 5'd5);
      step("rst_mid", 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd3);
      step("rst_hold", 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9);
      step("rst_write", 1'b0, 3'b100, 5'd4, 32'h55, 32'h0, 32'h0, 5'd4, 5'd2);
      step("rst_release", 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd10);
      for (int n = 0; n < 400; n++) begin
         logic [4:0] rd, r1, r2;
         rd = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         step("random", 1'b1, 3'($urandom_range(0, 7)), rd, $urandom, $urandom, $urandom,
              r1, r2);
      end
      step("wrap_idle", 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      @(posedge clk_i);
      #1;
      dut.wr_count_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      step("wrap_write", 1'b1, 3'b100, 5'd6, 32'h1234, 32'h0, 32'h0, 5'd6, 5'd0);
      step("wrap_done", 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd6, 5'd2);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_i);
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
